// File: rtl/multicycle_alu_if.sv
// Handshake and operand/result bundle for multicycle_alu.
// The master issues ops; the slave is the ALU itself.
interface multicycle_alu_if #(
    parameter int unsigned N = 8
) ();
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   ALUControl;
    logic         set_flags;
    logic [N-1:0] out;
    logic         negative;
    logic         zero;
    logic         carry_out;
    logic         overflow;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, ALUControl, set_flags,
        input  out, negative, zero, carry_out, overflow, busy, done
    );

    modport slave (
        input  start, a, b, ALUControl, set_flags,
        output out, negative, zero, carry_out, overflow, busy, done
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered ALU with NZCV flag register and an N-cycle shift-add unsigned multiplier.
// Single-cycle ops complete at the sampling edge; MUL holds busy for N cycles.
module multicycle_alu #(
    parameter int unsigned N = 8
) (
    input logic            clk,
    input logic            reset,
    multicycle_alu_if.slave bus
);
    localparam int unsigned ShW = $clog2(N);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpLsl = 3'b101;
    localparam logic [2:0] OpLsr = 3'b110;
    localparam logic [2:0] OpMul = 3'b111;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   out_q, out_d;
    logic [3:0]     flags_q, flags_d;  // {N, Z, C, V}
    logic           done_q, done_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [ShW-1:0] cnt_q, cnt_d;
    logic           sf_q, sf_d;

    logic [N-1:0]   alu_res;
    logic           alu_c, alu_v;
    logic [N-1:0]   b_op;
    logic [N:0]     sum;
    logic [ShW-1:0] sh;
    logic [2*N-1:0] lsl_w, lsr_w;
    logic [2*N-1:0] mul_sum;

    always_comb begin
        sh    = bus.b[ShW-1:0];
        b_op  = (bus.ALUControl == OpSub) ? ~bus.b : bus.b;
        sum   = {1'b0, bus.a} + {1'b0, b_op} + {{N{1'b0}}, bus.ALUControl == OpSub};
        // Wide shifts keep the last bit shifted out just beyond the result field.
        lsl_w = {{N{1'b0}}, bus.a} << sh;
        lsr_w = {bus.a, {N{1'b0}}} >> sh;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        unique case (bus.ALUControl)
            OpAdd, OpSub: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (bus.a[N-1] == b_op[N-1]) && (sum[N-1] != bus.a[N-1]);
            end
            OpAnd: alu_res = bus.a & bus.b;
            OpOr:  alu_res = bus.a | bus.b;
            OpXor: alu_res = bus.a ^ bus.b;
            OpLsl: begin
                alu_res = lsl_w[N-1:0];
                alu_c   = lsl_w[N];
            end
            OpLsr: begin
                alu_res = lsr_w[2*N-1:N];
                alu_c   = lsr_w[N-1];
            end
            OpMul: alu_res = '0;
            default: alu_res = '0;
        endcase
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sf_d     = sf_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.ALUControl == OpMul) begin
                        acc_d    = '0;
                        mcand_d  = {{N{1'b0}}, bus.a};
                        mplier_d = bus.b;
                        cnt_d    = '0;
                        sf_d     = bus.set_flags;
                        state_d  = StMul;
                    end else begin
                        out_d  = alu_res;
                        done_d = 1'b1;
                        if (bus.set_flags) begin
                            flags_d = {alu_res[N-1], alu_res == '0, alu_c, alu_v};
                        end
                    end
                end
            end
            StMul: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == ShW'(N - 1)) begin
                    out_d   = mul_sum[N-1:0];
                    done_d  = 1'b1;
                    state_d = StIdle;
                    if (sf_q) begin
                        flags_d = {mul_sum[N-1], mul_sum[N-1:0] == '0,
                                   |mul_sum[2*N-1:N], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            out_q    <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sf_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sf_q     <= sf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.negative  = flags_q[3];
    assign bus.zero      = flags_q[2];
    assign bus.carry_out = flags_q[1];
    assign bus.overflow  = flags_q[0];
    assign bus.busy      = (state_q == StMul);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [N-1:0] exp_out;
    logic [3:0]   exp_flags;

    multicycle_alu_if #(.N(N)) bus ();

    multicycle_alu #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {C, V, result} from plain integer arithmetic.
    function automatic logic [N+1:0] ref_alu(input logic [2:0] op, input logic [N-1:0] a,
                                             input logic [N-1:0] b);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint lim = longint'(1) << N;
        longint smax = (longint'(1) << (N - 1)) - 1;
        longint smin = -(longint'(1) << (N - 1));
        int sh = int'(b) % N;
        longint full;
        longint sfull;
        logic c = 1'b0;
        logic v = 1'b0;
        logic [N-1:0] r = '0;
        case (op)
            3'd0: begin
                full = ua + ub; r = N'(full); c = full >= lim;
                sfull = sa + sb; v = (sfull > smax) || (sfull < smin);
            end
            3'd1: begin
                full = ua - ub; r = N'(full); c = ua >= ub;
                sfull = sa - sb; v = (sfull > smax) || (sfull < smin);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                full = ua << sh; r = N'(full);
                c = (sh != 0) && (((ua >> (N - sh)) & 1) != 0);
            end
            3'd6: begin
                r = N'(ua >> sh);
                c = (sh != 0) && (((ua >> (sh - 1)) & 1) != 0);
            end
            default: begin
                full = ua * ub; r = N'(full); c = (full >> N) != 0;
            end
        endcase
        return {c, v, r};
    endfunction

    function automatic void model_update(input logic [2:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic sf);
        logic [N+1:0] m = ref_alu(op, a, b);
        exp_out = m[N-1:0];
        if (sf) exp_flags = {m[N-1], m[N-1:0] == '0, m[N+1], m[N]};
    endfunction

    function automatic logic [3:0] flags();
        return {bus.negative, bus.zero, bus.carry_out, bus.overflow};
    endfunction

    // Issue one op at a negedge, wait (bounded) for done, check timing, result and flags.
    task automatic do_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic sf, input bit poke);
        int lat = 1;
        int busy_cnt = 0;
        bit seen = 0;
        model_update(op, a, b, sf);
        bus.start = 1'b1; bus.ALUControl = op; bus.a = a; bus.b = b; bus.set_flags = sf;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = N'($urandom); bus.b = N'($urandom); bus.set_flags = 1'($urandom);
        while (!seen && lat <= 3 * N) begin
            if (bus.done) begin
                seen = 1;
            end else begin
                if (bus.busy) busy_cnt++;
                if (poke && lat == 3) begin
                    bus.start = 1'b1; bus.ALUControl = 3'd0;
                    bus.a = N'($urandom); bus.b = N'($urandom); bus.set_flags = 1'b1;
                end
                @(negedge clk);
                bus.start = 1'b0;
                lat++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("latency", lat, (op == 3'd7) ? N + 1 : 1);
        check("busy_cycles", busy_cnt, (op == 3'd7) ? N : 0);
        check("busy_at_done", 32'(bus.busy), 32'd0);
        check("out", 32'(bus.out), 32'(exp_out));
        check("flags", 32'(flags()), 32'(exp_flags));
        @(negedge clk);
        check("done_one_pulse", 32'(bus.done), 32'd0);
    endtask

    initial begin
        int seen_done;
        int guard;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.ALUControl = '0; bus.set_flags = 1'b0;
        reset = 1'b1;
        exp_out = '0; exp_flags = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out", 32'(bus.out), 32'd0);
        check("rst_flags", 32'(flags()), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);

        // Directed cases
        do_op(3'd0, 8'h7F, 8'h01, 1'b1, 0);
        check("add_ovf_flags", 32'(flags()), 32'b1001);
        do_op(3'd1, 8'h05, 8'h05, 1'b1, 0);
        check("sub_eq_flags", 32'(flags()), 32'b0110);
        do_op(3'd2, 8'hF0, 8'h0F, 1'b0, 0);
        check("and_hold_flags", 32'(flags()), 32'b0110);
        do_op(3'd7, 8'd15, 8'd17, 1'b1, 0);
        check("mul_255", 32'(bus.out), 32'hFF);
        do_op(3'd7, 8'd16, 8'd16, 1'b1, 0);
        check("mul_256_flags", 32'(flags()), 32'b0110);
        do_op(3'd7, 8'd3, 8'd5, 1'b1, 1);
        check("mul_poke_out", 32'(bus.out), 32'd15);
        do_op(3'd5, 8'h81, 8'd1, 1'b1, 0);
        check("lsl_out_c", 32'({bus.out, bus.carry_out}), 32'({8'h02, 1'b1}));
        do_op(3'd6, 8'h01, 8'd0, 1'b1, 0);
        check("lsr0_out_cz", 32'({bus.out, bus.carry_out, bus.zero}), 32'({8'h01, 2'b00}));

        // Back-to-back single-cycle ops, then a single-cycle op issued on MUL's done cycle
        model_update(3'd0, 8'd3, 8'd4, 1'b0);
        bus.start = 1'b1; bus.ALUControl = 3'd0; bus.a = 8'd3; bus.b = 8'd4; bus.set_flags = 0;
        @(negedge clk);
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_out1", 32'(bus.out), 32'(exp_out));
        model_update(3'd4, 8'hF0, 8'hFF, 1'b0);
        bus.ALUControl = 3'd4; bus.a = 8'hF0; bus.b = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_out2", 32'(bus.out), 32'(exp_out));
        model_update(3'd7, 8'd9, 8'd7, 1'b1);
        bus.start = 1'b1; bus.ALUControl = 3'd7; bus.a = 8'd9; bus.b = 8'd7; bus.set_flags = 1;
        @(negedge clk);
        bus.start = 1'b0;
        guard = 0;
        while (!bus.done && guard < 3 * N) begin
            @(negedge clk);
            guard++;
        end
        check("mul_b2b_out", 32'(bus.out), 32'(exp_out));
        model_update(3'd0, 8'd10, 8'd20, 1'b1);
        bus.start = 1'b1; bus.ALUControl = 3'd0; bus.a = 8'd10; bus.b = 8'd20;
        @(negedge clk);
        bus.start = 1'b0;
        check("after_mul_done", 32'(bus.done), 32'd1);
        check("after_mul_out", 32'(bus.out), 32'(exp_out));
        check("after_mul_flags", 32'(flags()), 32'(exp_flags));

        // Reset four cycles into a multiply aborts it
        do_op(3'd0, 8'h7F, 8'h01, 1'b1, 0);
        bus.start = 1'b1; bus.ALUControl = 3'd7; bus.a = 8'd15; bus.b = 8'd17;
        bus.set_flags = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_out = '0; exp_flags = '0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_out", 32'(bus.out), 32'd0);
        check("abort_flags", 32'(flags()), 32'd0);
        seen_done = 0;
        repeat (2 * N) begin
            if (bus.done) seen_done++;
            @(negedge clk);
        end
        check("abort_no_done", seen_done, 0);

        // Randomized ops against the model
        for (int i = 0; i < 150; i++) begin
            do_op(3'($urandom_range(0, 7)), N'($urandom), N'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
